// File: rtl/ras_ckpt.sv
// Return-address stack with checkpoint recovery for branch-mispredict repair.
// Ports: clk/rst, flush, push/pop requests, recover inputs; top/ckpt outputs, overflow/underflow pulses.
module ras_ckpt #(
  parameter int ENTRIES_NUM = 8,
  parameter int DATA_WIDTH  = 32,
  localparam int PTR_W = $clog2(ENTRIES_NUM),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_req,
  input  logic                  pop_req,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  recover_req,
  input  logic [PTR_W-1:0]      recover_ptr,
  input  logic [CNT_W-1:0]      recover_cnt,
  input  logic [DATA_WIDTH-1:0] recover_data,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic                  top_valid,
  output logic [PTR_W-1:0]      ckpt_ptr,
  output logic [CNT_W-1:0]      ckpt_cnt,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(ENTRIES_NUM);

  logic [DATA_WIDTH-1:0] mem [ENTRIES_NUM];
  logic [PTR_W-1:0]      tos;
  logic [CNT_W-1:0]      cnt;
  logic [PTR_W-1:0]      tos_inc;
  logic [PTR_W-1:0]      tos_dec;

  // Pointer arithmetic wraps naturally: depth is a power of two.
  assign tos_inc = tos + 1'b1;
  assign tos_dec = tos - 1'b1;

  assign top_data  = mem[tos];
  assign top_valid = (cnt != '0);
  assign ckpt_ptr  = tos;
  assign ckpt_cnt  = cnt;

  always_ff @(posedge clk) begin
    overflow  <= 1'b0;
    underflow <= 1'b0;
    if (rst) begin
      tos <= '0;
      cnt <= '0;
      for (int i = 0; i < ENTRIES_NUM; i++) mem[i] <= '0;
    end else if (flush) begin
      tos <= '0;
      cnt <= '0;
    end else if (recover_req) begin
      tos <= recover_ptr;
      cnt <= (recover_cnt > FULL) ? FULL : recover_cnt;
      if (recover_cnt != '0) mem[recover_ptr] <= recover_data;
    end else if (push_req && pop_req) begin
      // Return immediately followed by a call: replace top in place.
      mem[tos] <= push_data;
      if (cnt == '0) cnt <= CNT_W'(1);
    end else if (push_req) begin
      tos          <= tos_inc;
      mem[tos_inc] <= push_data;
      // When full, tos+1 is the oldest slot, so it is overwritten.
      if (cnt == FULL) overflow <= 1'b1;
      else             cnt      <= cnt + 1'b1;
    end else if (pop_req) begin
      if (cnt == '0) begin
        underflow <= 1'b1;
      end else begin
        tos <= tos_dec;
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ras_ckpt.sv
// Randomised bench for ras_ckpt with a queue-free array model and directed pins.
// Drives stimulus after each rising edge, compares all outputs on falling edges.
module tb_ras_ckpt;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int PW = 2;
  localparam int CW = 3;

  logic          clk = 0;
  logic          rst = 0, flush = 0, push_req = 0, pop_req = 0, recover_req = 0;
  logic [DW-1:0] push_data = 0, recover_data = 0;
  logic [PW-1:0] recover_ptr = 0;
  logic [CW-1:0] recover_cnt = 0;
  logic [DW-1:0] top_data;
  logic          top_valid, overflow, underflow;
  logic [PW-1:0] ckpt_ptr;
  logic [CW-1:0] ckpt_cnt;

  ras_ckpt #(.ENTRIES_NUM(N), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push_req(push_req),
    .pop_req(pop_req), .push_data(push_data), .recover_req(recover_req),
    .recover_ptr(recover_ptr), .recover_cnt(recover_cnt),
    .recover_data(recover_data), .top_data(top_data),
    .top_valid(top_valid), .ckpt_ptr(ckpt_ptr), .ckpt_cnt(ckpt_cnt),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 0;

  // Model: logical stack contents as an array indexed by slot number.
  int unsigned m_mem [N];
  bit          m_known [N];
  int          m_tos, m_cnt;
  bit          m_ovf, m_unf;

  task automatic check(string name, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    m_ovf = 0;
    m_unf = 0;
    if (rst) begin
      m_tos = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) begin m_mem[i] = 0; m_known[i] = 1; end
    end else if (flush) begin
      m_tos = 0; m_cnt = 0;
      for (int i = 0; i < N; i++) m_known[i] = 0;
    end else if (recover_req) begin
      m_tos = recover_ptr;
      m_cnt = (recover_cnt > N) ? N : recover_cnt;
      if (recover_cnt != 0) begin
        m_mem[recover_ptr] = recover_data; m_known[recover_ptr] = 1;
      end
    end else if (push_req && pop_req) begin
      m_mem[m_tos] = push_data; m_known[m_tos] = 1;
      if (m_cnt < 1) m_cnt = 1;
    end else if (push_req) begin
      m_ovf = (m_cnt == N);
      m_tos = (m_tos + 1) % N;
      m_mem[m_tos] = push_data; m_known[m_tos] = 1;
      if (m_cnt < N) m_cnt++;
    end else if (pop_req) begin
      if (m_cnt == 0) m_unf = 1;
      else begin m_tos = (m_tos + N - 1) % N; m_cnt--; end
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("ckpt_ptr", ckpt_ptr, m_tos);
      check("ckpt_cnt", ckpt_cnt, m_cnt);
      check("top_valid", top_valid, m_cnt != 0);
      check("overflow", overflow, m_ovf);
      check("underflow", underflow, m_unf);
      if (m_known[m_tos]) check("top_data", top_data, m_mem[m_tos]);
    end
  end

  task automatic step(bit r, bit f, bit pu, bit po, int unsigned d,
                      bit rc = 0, int rp = 0, int rn = 0, int unsigned rd = 0);
    rst = r; flush = f; push_req = pu; pop_req = po; push_data = d;
    recover_req = rc; recover_ptr = PW'(rp); recover_cnt = CW'(rn);
    recover_data = rd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  int unsigned exp_pop [4];

  initial begin
    // Reset
    step(1, 0, 1, 1, 32'hDEAD);
    chk_on = 1;
    check("rst_valid", top_valid, 0);
    check("rst_data", top_data, 0);
    check("rst_cnt", ckpt_cnt, 0);
    check("rst_ptr", ckpt_ptr, 0);

    // Overflow wrap
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0, 32'h100 + 4 * i);
      check("ovf_pulse", overflow, i == 4);
    end
    check("ovf_cnt", ckpt_cnt, 4);
    idle();
    check("ovf_drop", overflow, 0);
    exp_pop = '{32'h110, 32'h10C, 32'h108, 32'h104};
    for (int i = 0; i < 4; i++) begin
      check("pop_data", top_data, exp_pop[i]);
      step(0, 0, 0, 1, 0);
    end
    check("pop_empty", top_valid, 0);

    // Underflow
    step(0, 0, 0, 1, 0);
    check("unf_pulse", underflow, 1);
    check("unf_ptr", ckpt_ptr, 1);
    check("unf_cnt", ckpt_cnt, 0);
    idle();
    check("unf_drop", underflow, 0);

    // Simultaneous push and pop
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'hA0);
    step(0, 0, 1, 0, 32'hB0);
    step(0, 0, 1, 1, 32'hC0);
    check("pp_data", top_data, 32'hC0);
    check("pp_cnt", ckpt_cnt, 2);
    check("pp_ptr", ckpt_ptr, 2);
    step(0, 0, 0, 1, 0);
    check("pp_pop", top_data, 32'hA0);

    // Recovery
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h200);
    check("cap_ptr", ckpt_ptr, 1);
    check("cap_cnt", ckpt_cnt, 1);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 32'h300);
    step(0, 0, 1, 0, 32'h304);
    step(0, 0, 1, 1, 32'h999, 1, 1, 1, 32'h200);
    check("rec_data", top_data, 32'h200);
    check("rec_ptr", ckpt_ptr, 1);
    check("rec_cnt", ckpt_cnt, 1);

    // Flush beats push
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 32'h40 + i);
    check("pre_flush", ckpt_cnt, 3);
    step(0, 1, 1, 0, 32'h77);
    check("fl_valid", top_valid, 0);
    check("fl_cnt", ckpt_cnt, 0);
    check("fl_ptr", ckpt_ptr, 0);
    check("fl_ovf", overflow, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned sel = $urandom_range(0, 99);
      step(sel < 2, (sel >= 2 && sel < 5), $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom(),
           (sel >= 5 && sel < 12), $urandom_range(0, N - 1),
           $urandom_range(0, 7), $urandom());
    end
    idle();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
